// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD converters: FSM states, default digit
// count, binary width computation and the nibble constants used by the
// reverse double-dabble correction.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int unsigned DIGITS_DEF = 4;

   localparam logic [3:0] NIB_ADJ_TH  = 4'd8;
   localparam logic [3:0] NIB_ADJ_SUB = 4'd3;
   localparam logic [3:0] NIB_MAX     = 4'd9;

   // ceil(log2(10^digits)): bit length of the largest value, 10^digits-1.
   // 10^digits is never a power of two, so the two are equal.
   function automatic int unsigned bin_width(input int unsigned digits);
      longint unsigned v;
      int unsigned     w;
      v = 64'd1;
      w = 0;
      for (int unsigned i = 0; i < digits; i++) begin
         v = v * 64'd10;
      end
      v = v - 64'd1;
      while (v != 64'd0) begin
         w++;
         v = v >> 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: after a right shift a
// nibble that received a bit from its upper neighbour (weight 8, should be
// weight 5) is pulled back by 3.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   // Subtract 3 from any nibble that is 8 or above
   always_comb begin
      o_nib = i_nib;
      if (i_nib >= NIB_ADJ_TH) begin
         o_nib = i_nib - NIB_ADJ_SUB;
      end
   end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Packed BCD to binary converter using reverse double-dabble, one bit per
// cycle. Digit 0 lives in bcd_in[3:0], matching the binary-to-BCD converter.
// Optional macro BCD2BIN_ERROR_CHECK_EN: invalid digits (>9) skip the shift
// phase and report error=1 with binary_out=0.
module bcd_to_binary_converter
   import bcd_pkg::*;
#(
   parameter  int unsigned DIGITS = DIGITS_DEF,
   localparam int unsigned BIN_W  = bin_width(DIGITS)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [BIN_W-1:0]      binary_out,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned   SHIFTS   = 4 * DIGITS;
   localparam int unsigned   CW       = $clog2(SHIFTS);
   localparam logic [CW-1:0] CNT_LAST = CW'(SHIFTS - 1);

   state_t              r_state;
   state_t              w_next;
   logic [SHIFTS-1:0]   r_bcd;
   logic [SHIFTS-1:0]   r_bin;
   logic [SHIFTS-1:0]   w_shift_bcd;
   logic [SHIFTS-1:0]   w_shift_bin;
   logic [SHIFTS-1:0]   w_adj_bcd;
   logic [CW-1:0]       r_cnt;
   logic                w_cnt_last;
   logic [BIN_W-1:0]    r_out;

   // The bin register is SHIFTS wide so that after SHIFTS shifts the value
   // sits right-aligned; its top bits are zero for any valid input.
   assign w_shift_bcd = {1'b0, r_bcd[SHIFTS-1:1]};
   assign w_shift_bin = {r_bcd[0], r_bin[SHIFTS-1:1]};
   assign w_cnt_last  = (r_cnt == CNT_LAST);

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .i_nib (w_shift_bcd[4*g +: 4]),
         .o_nib (w_adj_bcd[4*g +: 4])
      );
   end

`ifdef BCD2BIN_ERROR_CHECK_EN
   logic [DIGITS-1:0] w_nib_bad;
   logic              w_bad;
   logic              r_err;

   for (genvar g = 0; g < DIGITS; g++) begin : g_chk
      assign w_nib_bad[g] = (bcd_in[4*g +: 4] > NIB_MAX);
   end
   assign w_bad = |w_nib_bad;
   assign error = r_err;
`else
   assign error = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and status outputs
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
`ifdef BCD2BIN_ERROR_CHECK_EN
               w_next = w_bad ? ST_DONE : ST_SHIFT;
`else
               w_next = ST_SHIFT;
`endif
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (w_cnt_last) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Datapath: capture, shift/adjust, and result load on entry to DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcd <= '0;
         r_bin <= '0;
         r_cnt <= '0;
         r_out <= '0;
`ifdef BCD2BIN_ERROR_CHECK_EN
         r_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bcd <= bcd_in;
                  r_bin <= '0;
                  r_cnt <= '0;
`ifdef BCD2BIN_ERROR_CHECK_EN
                  if (w_bad) begin
                     r_out <= '0;
                     r_err <= 1'b1;
                  end
`endif
               end
            end
            ST_SHIFT: begin
               r_bcd <= w_adj_bcd;
               r_bin <= w_shift_bin;
               r_cnt <= r_cnt + 1'b1;
               // Final shift result goes straight to the output so it is
               // valid during the DONE cycle.
               if (w_cnt_last) begin
                  r_out <= w_shift_bin[BIN_W-1:0];
`ifdef BCD2BIN_ERROR_CHECK_EN
                  r_err <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign binary_out = r_out;

endmodule
